// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and byte-merge helper shared by the data-memory responder and its array
package dmem_pkg;
  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage, synchronous read, byte-enabled synchronous write, no reset
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_en) begin
      if (i_we) r_mem[i_idx] <= byte_merge(r_mem[i_idx], i_wdata, i_wstrb);
      o_rdata <= i_we ? '0 : r_mem[i_idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: dm_* target with request/grant handshake, configurable wait states and address checking
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_M1   = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
  localparam bit          ZERO_LAT = LATENCY == 0;

  dm_state_e     r_state;
  logic [3:0]    r_cnt;
  logic          r_we, r_err, r_derr, r_ld;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   w_off, w_rdata, w_cur_wdata;
  logic          w_err, w_go, w_cur_we, w_cur_err;
  logic [AW-1:0] w_cur_idx;
  logic [3:0]    w_cur_wstrb;

  // Addresses below the base wrap to a huge offset, so one compare covers both range ends
  assign w_off  = dm_addr - ADDR_BASE;
  assign w_err  = |dm_addr[1:0] | ({1'b0, w_off} >= SPAN);
  assign dm_gnt = rst & dm_req & (r_state == DM_IDLE | r_state == DM_RESP);

  // With no wait states the array is accessed on the grant edge, straight from the request
  assign w_go        = ZERO_LAT ? dm_gnt : rst & r_state == DM_WAIT & r_cnt == 4'd0;
  assign w_cur_we    = ZERO_LAT ? dm_we : r_we;
  assign w_cur_err   = ZERO_LAT ? w_err : r_err;
  assign w_cur_idx   = ZERO_LAT ? w_off[AW+1:2] : r_idx;
  assign w_cur_wdata = ZERO_LAT ? dm_wdata : r_wdata;
  assign w_cur_wstrb = ZERO_LAT ? dm_wstrb : r_wstrb;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .i_en    (w_go & ~w_cur_err),
    .i_we    (w_cur_we),
    .i_idx   (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .i_wstrb (w_cur_wstrb),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= DM_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_derr  <= 1'b0;
      r_ld    <= 1'b0;
    end else begin
      r_derr <= w_go & w_cur_err;
      r_ld   <= w_go & ~w_cur_err & ~w_cur_we;
      if (dm_gnt) begin
        r_we    <= dm_we;
        r_err   <= w_err;
        r_idx   <= w_off[AW+1:2];
        r_wdata <= dm_wdata;
        r_wstrb <= dm_wstrb;
        r_cnt   <= LAT_M1;
        r_state <= ZERO_LAT ? DM_RESP : DM_WAIT;
      end else if (r_state == DM_WAIT) begin
        r_cnt   <= r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
        r_state <= r_cnt == 4'd0 ? DM_RESP : DM_WAIT;
      end else r_state <= DM_IDLE;
    end

  assign dm_rvalid = r_state == DM_RESP;
  assign dm_err    = r_derr;
  assign dm_rdata  = r_ld ? w_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responders (LATENCY 0..3, one with a nonzero base) checked against a word-array model
module tb_dmem_responder;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req [4], we [4], gnt [4], rvalid [4], err [4];
  logic [31:0] addr [4], wdata [4], rdata [4];
  logic [3:0]  strb [4];
  logic [31:0] mdl [4][16];
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(.DEPTH(16), .ADDR_BASE(g == 3 ? 32'h400 : 32'h0), .LATENCY(g)) u_dut (
      .clk(clk), .rst(rst), .dm_req(req[g]), .dm_we(we[g]), .dm_addr(addr[g]),
      .dm_wdata(wdata[g]), .dm_wstrb(strb[g]), .dm_gnt(gnt[g]), .dm_rvalid(rvalid[g]),
      .dm_rdata(rdata[g]), .dm_err(err[g])
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] off;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] base_of(input int d);
    return d == 3 ? 32'h400 : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One complete request on DUT d: wait for grant, then expect the response exactly d+1 cycles later
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output logic [31:0] rd, output logic er);
    logic [32:0] off;
    logic        e_err;
    logic [31:0] e_rd;
    logic [3:0]  ix;
    int          n;
    off   = {1'b0, a} - {1'b0, base_of(d)};
    e_err = (a[1:0] != 2'b00) || (off >= 33'd64);
    ix    = off[5:2];
    e_rd  = (e_err || w) ? 32'h0 : mdl[d][ix];
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; strb[d] = s;
    n = 0;
    #1;
    while (!gnt[d] && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant", 32'(gnt[d]), 32'd1);
    @(negedge clk);
    req[d] = 1'b0;
    n = 1;
    #1;
    while (!rvalid[d] && n < 20) begin @(negedge clk); #1; n++; end
    chk("latency", n, d + 1);
    chk("rdata", rdata[d], e_rd);
    chk("err", 32'(err[d]), 32'(e_err));
    rd = rdata[d];
    er = err[d];
    if (w && !e_err)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[d][ix][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    logic [31:0] x, a;
    logic        xe, seen;
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,       32'h000000AA, 4'h1, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b0, 32'h12,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h40,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h12,       32'h55555555, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[8]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[11] = '{1'b1, 32'h3C,       32'hCAFEF00D, 4'hA, 32'h0,        1'b0};
    for (int d = 0; d < 4; d++) begin
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = base_of(d); wdata[d] = '0; strb[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset gnt", 32'(gnt[d]), 32'd0);
      chk("reset rvalid", 32'(rvalid[d]), 32'd0);
      chk("reset rdata", rdata[d], 32'd0);
      chk("reset err", 32'(err[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) chk("first gnt", 32'(gnt[d]), 32'd1);
    @(negedge clk);
    for (int d = 0; d < 4; d++) req[d] = 1'b0;
    repeat (5) @(negedge clk);

    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 16; i++) txn(d, 1'b1, base_of(d) + 32'(4 * i), $urandom, 4'hF, x, xe);

    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 12; k++) begin
        txn(d, tbl[k].we, base_of(d) + tbl[k].off, tbl[k].wd, tbl[k].s, x, xe);
        chk("table rdata", x, tbl[k].erd);
        chk("table err", 32'(xe), 32'(tbl[k].eerr));
      end

    // Back-to-back loads on LATENCY 1: second grant lands on the first response
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
    #1; chk("b2b gnt1", 32'(gnt[1]), 32'd1);
    @(negedge clk);
    addr[1] = 32'h14;
    #1; chk("b2b wait gnt", 32'(gnt[1]), 32'd0);
    chk("b2b wait rvalid", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    #1; chk("b2b rvalid1", 32'(rvalid[1]), 32'd1);
    chk("b2b gnt2", 32'(gnt[1]), 32'd1);
    chk("b2b rdata1", rdata[1], mdl[1][4]);
    @(negedge clk);
    req[1] = 1'b0;
    #1; chk("b2b gap", 32'(rvalid[1]), 32'd0);
    @(negedge clk);
    #1; chk("b2b rvalid2", 32'(rvalid[1]), 32'd1);
    chk("b2b rdata2", rdata[1], mdl[1][5]);
    @(negedge clk);

    // Reset during WAIT on LATENCY 3 must drop the store and its response
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h420; wdata[3] = 32'h12345678; strb[3] = 4'hF;
    #1; chk("midwait gnt", 32'(gnt[3]), 32'd1);
    @(negedge clk);
    req[3] = 1'b0;
    #1; chk("midwait rvalid", 32'(rvalid[3]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); #1; if (rvalid[3]) seen = 1'b1; end
    chk("no resp after reset", 32'(seen), 32'd0);
    txn(3, 1'b0, 32'h420, 32'h0, 4'h0, x, xe);
    chk("store discarded", x, mdl[3][8]);

    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 60; k++) begin
        a = base_of(d) + 32'($urandom_range(0, 20) << 2);
        if ($urandom % 6 == 0) a = a + 32'($urandom_range(1, 3));
        if (d == 3 && $urandom % 8 == 0) a = base_of(d) - 32'(4 * $urandom_range(1, 4));
        txn(d, 1'($urandom), a, $urandom, 4'($urandom), x, xe);
        repeat ($urandom % 3) @(negedge clk);
      end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
